pspin_pkt_alloc: RTL and testbench

- Ingress packet-buffer allocator. Sits between the matching engine and the ingress DMA, directly upstream of the HER generator.
- Assigns each matched packet a fixed-size slot in PsPIN L2 packet memory and issues a DMA write descriptor. The descriptor tag carries msgid/is_eom/ctx_id, which the HER generator later decodes from the DMA completion.
- Slots are returned through a feedback port when PsPIN finishes the handler. Frees may arrive in any order.

---
 rtl/pspin_pkt_alloc_pkg.sv | 31 +++
 rtl/pspin_pkt_alloc_lowest_set.sv | 21 ++
 rtl/pspin_pkt_alloc.sv | 186 ++++++++++++++++++
 tb/tb_pspin_pkt_alloc.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pspin_pkt_alloc_pkg.sv
// Shared definitions for the ingress packet-buffer allocator and the HER
// generator: default L2 buffer placement, DMA tag field layout and the
// output-register state encoding.
package pspin_pkt_alloc_pkg;

  // Default placement of the packet buffer in L2.
  localparam logic [31:0] DEFAULT_BUF_BASE  = 32'h1C30_0000;
  localparam int unsigned DEFAULT_SLOT_SIZE = 32'd2048;

  // DMA tag layout: ctx_id in the LSBs, then is_eom, then msgid.
  // The HER generator decodes completions with these same positions.
  localparam int unsigned TAG_CTX_LSB = 32'd0;

  function automatic int unsigned tag_eom_pos(input int unsigned ctx_w);
    return ctx_w;
  endfunction

  function automatic int unsigned tag_msgid_lsb(input int unsigned ctx_w);
    return ctx_w + 32'd1;
  endfunction

  function automatic logic is_pow2(input longint unsigned v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_e;

endpackage

// File: rtl/pspin_pkt_alloc_lowest_set.sv
// Priority encoder: index of the lowest set bit of a vector plus an
// any-set flag. Purely combinational.
module pspin_lowest_set #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = {IDX_W{1'b0}};
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      idx_o = vec_i[i] ? IDX_W'(i) : idx_o;
    end
    any_o = |vec_i;
  end

endmodule

// File: rtl/pspin_pkt_alloc.sv
// Ingress packet-buffer allocator: hands each matched packet a fixed-size
// L2 slot, emits a DMA write descriptor (one-entry output register) and
// takes slots back through an out-of-order free port.
module pspin_pkt_alloc
  import pspin_pkt_alloc_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH       = 20,
  parameter int unsigned TAG_WIDTH       = 32,
  parameter int unsigned C_MSGID_WIDTH   = 10,
  parameter int unsigned NUM_HANDLER_CTX = 8,
  parameter logic [AXI_ADDR_WIDTH-1:0] BUF_BASE = AXI_ADDR_WIDTH'(DEFAULT_BUF_BASE),
  parameter int unsigned SLOT_SIZE       = DEFAULT_SLOT_SIZE,
  parameter int unsigned NUM_SLOTS       = 64,
  parameter int unsigned CTX_ID_WIDTH    = $clog2(NUM_HANDLER_CTX)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [LEN_WIDTH-1:0]          pkt_len,
  input  logic [C_MSGID_WIDTH-1:0]      pkt_msgid,
  input  logic                          pkt_is_eom,
  input  logic [CTX_ID_WIDTH-1:0]       pkt_ctx_id,
  input  logic                          pkt_valid,
  output logic                          pkt_ready,
  output logic [AXI_ADDR_WIDTH-1:0]     write_desc_addr,
  output logic [LEN_WIDTH-1:0]          write_desc_len,
  output logic [TAG_WIDTH-1:0]          write_desc_tag,
  output logic                          write_desc_valid,
  input  logic                          write_desc_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]     feedback_addr,
  input  logic                          feedback_valid,
  output logic [$clog2(NUM_SLOTS):0]    free_count,
  output logic [31:0]                   trunc_count,
  output logic [31:0]                   free_err_count
);

  localparam int unsigned SLOT_IDX_W = $clog2(NUM_SLOTS);
  localparam int unsigned SLOT_SHIFT = $clog2(SLOT_SIZE);
  localparam int unsigned CNT_W      = SLOT_IDX_W + 1;
  localparam int unsigned EOM_POS    = tag_eom_pos(CTX_ID_WIDTH);
  localparam int unsigned MSGID_LSB  = tag_msgid_lsb(CTX_ID_WIDTH);
  localparam logic [AXI_ADDR_WIDTH:0] REGION_BYTES = (AXI_ADDR_WIDTH + 1)'(NUM_SLOTS) << SLOT_SHIFT;
  localparam logic [LEN_WIDTH-1:0]    SLOT_LEN     = LEN_WIDTH'(SLOT_SIZE);
  localparam logic [CNT_W-1:0]        ALL_FREE_CNT = CNT_W'(NUM_SLOTS);
  localparam logic [31:0]             CNT_MAX      = 32'hFFFF_FFFF;

  if (C_MSGID_WIDTH + 1 + CTX_ID_WIDTH > TAG_WIDTH) begin : g_err_tag
    $error("pspin_pkt_alloc: tag fields do not fit in TAG_WIDTH");
  end
  if (!is_pow2(64'(SLOT_SIZE))) begin : g_err_slot
    $error("pspin_pkt_alloc: SLOT_SIZE must be a power of 2");
  end
  if (!is_pow2(64'(NUM_SLOTS))) begin : g_err_num
    $error("pspin_pkt_alloc: NUM_SLOTS must be a power of 2");
  end

  out_state_e                state_q, state_d;
  logic [NUM_SLOTS-1:0]      bitmap_q, bitmap_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [TAG_WIDTH-1:0]      tag_q, tag_d;
  logic [CNT_W-1:0]          free_cnt_q, free_cnt_d;
  logic [31:0]               trunc_q, trunc_d;
  logic [31:0]               ferr_q, ferr_d;

  logic [SLOT_IDX_W-1:0]     low_idx_s;
  logic                      any_free_s;
  logic                      accept_s;
  logic                      trunc_s;
  logic [AXI_ADDR_WIDTH-1:0] fb_off_s;
  logic [SLOT_IDX_W-1:0]     fb_slot_s;
  logic                      fb_ok_s;

  pspin_lowest_set #(
    .WIDTH (NUM_SLOTS),
    .IDX_W (SLOT_IDX_W)
  ) u_lowest (
    .vec_i (bitmap_q),
    .idx_o (low_idx_s),
    .any_o (any_free_s)
  );

  assign pkt_ready = rstn && any_free_s && ((state_q == OUT_EMPTY) || write_desc_ready);
  assign accept_s  = pkt_valid && pkt_ready;

  // Decode a returned slot address; only an aligned, in-range, currently allocated slot is accepted.
  always_comb begin
    fb_off_s  = feedback_addr - BUF_BASE;
    fb_slot_s = fb_off_s[SLOT_SHIFT +: SLOT_IDX_W];
    fb_ok_s   = feedback_valid
             && (feedback_addr >= BUF_BASE)
             && ({1'b0, fb_off_s} < REGION_BYTES)
             && (fb_off_s[SLOT_SHIFT-1:0] == {SLOT_SHIFT{1'b0}})
             && !bitmap_q[fb_slot_s];
  end

  // Next-state of bitmap, descriptor data and counters; allocation sees the pre-free bitmap.
  always_comb begin
    trunc_s    = (pkt_len > SLOT_LEN);
    bitmap_d   = bitmap_q;
    addr_d     = addr_q;
    len_d      = len_q;
    tag_d      = tag_q;
    trunc_d    = trunc_q;
    ferr_d     = ferr_q;
    free_cnt_d = free_cnt_q;
    if (accept_s) begin
      bitmap_d[low_idx_s] = 1'b0;
      addr_d = BUF_BASE + (AXI_ADDR_WIDTH'(low_idx_s) << SLOT_SHIFT);
      len_d  = trunc_s ? SLOT_LEN : pkt_len;
      tag_d  = {TAG_WIDTH{1'b0}};
      tag_d[TAG_CTX_LSB +: CTX_ID_WIDTH] = pkt_ctx_id;
      tag_d[EOM_POS]                     = pkt_is_eom;
      tag_d[MSGID_LSB +: C_MSGID_WIDTH]  = pkt_msgid;
      if (trunc_s && (trunc_q != CNT_MAX)) begin
        trunc_d = trunc_q + 32'd1;
      end else begin
        trunc_d = trunc_q;
      end
    end else begin
      bitmap_d = bitmap_q;
    end
    // The freed slot was allocated, so it never collides with the slot just taken.
    if (fb_ok_s) begin
      bitmap_d[fb_slot_s] = 1'b1;
    end else if (feedback_valid && (ferr_q != CNT_MAX)) begin
      ferr_d = ferr_q + 32'd1;
    end else begin
      ferr_d = ferr_q;
    end
    case ({fb_ok_s, accept_s})
      2'b10:   free_cnt_d = free_cnt_q + CNT_W'(1);
      2'b01:   free_cnt_d = free_cnt_q - CNT_W'(1);
      default: free_cnt_d = free_cnt_q;
    endcase
  end

  // Output register FSM: EMPTY until an accept, HOLD until the DMA takes the descriptor.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: begin
        if (accept_s) state_d = OUT_HOLD;
        else          state_d = OUT_EMPTY;
      end
      OUT_HOLD: begin
        if (accept_s)              state_d = OUT_HOLD;
        else if (write_desc_ready) state_d = OUT_EMPTY;
        else                       state_d = OUT_HOLD;
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  // State registers with synchronous active-low reset; reset frees every slot and drops any held descriptor.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= OUT_EMPTY;
      bitmap_q   <= {NUM_SLOTS{1'b1}};
      addr_q     <= {AXI_ADDR_WIDTH{1'b0}};
      len_q      <= {LEN_WIDTH{1'b0}};
      tag_q      <= {TAG_WIDTH{1'b0}};
      free_cnt_q <= ALL_FREE_CNT;
      trunc_q    <= 32'd0;
      ferr_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      bitmap_q   <= bitmap_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      tag_q      <= tag_d;
      free_cnt_q <= free_cnt_d;
      trunc_q    <= trunc_d;
      ferr_q     <= ferr_d;
    end
  end

  assign write_desc_valid = (state_q == OUT_HOLD);
  assign write_desc_addr  = addr_q;
  assign write_desc_len   = len_q;
  assign write_desc_tag   = tag_q;
  assign free_count       = free_cnt_q;
  assign trunc_count      = trunc_q;
  assign free_err_count   = ferr_q;

endmodule

// File: tb/tb_pspin_pkt_alloc.sv
// Directed bench for pspin_pkt_alloc with a reference model of the slot
// bitmap and a descriptor scoreboard.
module tb_pspin_pkt_alloc;

  localparam logic [31:0] BASE = 32'h1C30_0000;

  typedef struct {
    logic [31:0] addr;
    logic [19:0] len;
    logic [31:0] tag;
  } desc_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [19:0] pkt_len;
  logic [9:0]  pkt_msgid;
  logic        pkt_is_eom;
  logic [2:0]  pkt_ctx_id;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [31:0] write_desc_addr;
  logic [19:0] write_desc_len;
  logic [31:0] write_desc_tag;
  logic        write_desc_valid;
  logic        write_desc_ready;
  logic [31:0] feedback_addr;
  logic        feedback_valid;
  logic [6:0]  free_count;
  logic [31:0] trunc_count;
  logic [31:0] free_err_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_bm;
  bit          m_hold;
  int          m_trunc;
  int          m_ferr;
  desc_t       sb_q[$];

  pspin_pkt_alloc dut (
    .clk              (clk),
    .rstn             (rstn),
    .pkt_len          (pkt_len),
    .pkt_msgid        (pkt_msgid),
    .pkt_is_eom       (pkt_is_eom),
    .pkt_ctx_id       (pkt_ctx_id),
    .pkt_valid        (pkt_valid),
    .pkt_ready        (pkt_ready),
    .write_desc_addr  (write_desc_addr),
    .write_desc_len   (write_desc_len),
    .write_desc_tag   (write_desc_tag),
    .write_desc_valid (write_desc_valid),
    .write_desc_ready (write_desc_ready),
    .feedback_addr    (feedback_addr),
    .feedback_valid   (feedback_valid),
    .free_count       (free_count),
    .trunc_count      (trunc_count),
    .free_err_count   (free_err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [63:0] bm);
    for (int i = 0; i < 64; i++) begin
      if (bm[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_bm    = {64{1'b1}};
    m_hold  = 1'b0;
    m_trunc = 0;
    m_ferr  = 0;
    sb_q.delete();
  endtask

  // One clock: predict ready/accept/free from the model, advance, then check state.
  task automatic tick();
    logic   exp_ready;
    logic   acc;
    longint off;
    int     fslot;
    bit     fok;
    int     s;
    desc_t  d;
    #1;
    exp_ready = (m_bm != 64'd0) && (!m_hold || write_desc_ready);
    chk("pkt_ready", pkt_ready, exp_ready);
    acc   = pkt_valid && exp_ready;
    fok   = 1'b0;
    fslot = 0;
    if (feedback_valid) begin
      off = longint'(feedback_addr) - longint'(BASE);
      if (off >= 0 && off < 64 * 2048 && (off % 2048) == 0 && m_bm[int'(off / 2048)] == 1'b0) begin
        fok   = 1'b1;
        fslot = int'(off / 2048);
      end else begin
        m_ferr++;
      end
    end
    if (acc) begin
      s      = lowest(m_bm);
      d.addr = BASE + 32'(s) * 32'h800;
      d.len  = (pkt_len > 20'd2048) ? 20'd2048 : pkt_len;
      d.tag  = {18'd0, pkt_msgid, pkt_is_eom, pkt_ctx_id};
      sb_q.push_back(d);
      m_bm[s] = 1'b0;
      if (pkt_len > 20'd2048) m_trunc++;
    end
    if (fok) m_bm[fslot] = 1'b1;
    if (acc) m_hold = 1'b1;
    else if (write_desc_ready) m_hold = 1'b0;
    @(posedge clk);
    #2;
    chk("desc_valid", write_desc_valid, m_hold);
    chk("free_count", free_count, $countones(m_bm));
    chk("trunc_count", trunc_count, m_trunc);
    chk("free_err_count", free_err_count, m_ferr);
  endtask

  task automatic do_reset();
    rstn           = 1'b0;
    pkt_valid      = 1'b0;
    feedback_valid = 1'b0;
    @(posedge clk);
    #2;
    model_reset();
    chk("reset_free", free_count, 64);
    chk("reset_valid", write_desc_valid, 0);
    rstn = 1'b1;
  endtask

  // Scoreboard: compare each descriptor the DMA takes against the oldest prediction.
  always @(negedge clk) begin
    desc_t d;
    if (rstn === 1'b1 && write_desc_valid === 1'b1 && write_desc_ready === 1'b1) begin
      chk("sb_has_entry", sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) begin
        d = sb_q.pop_front();
        chk("sb_addr", write_desc_addr, d.addr);
        chk("sb_len", write_desc_len, d.len);
        chk("sb_tag", write_desc_tag, d.tag);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    rstn             = 1'b0;
    pkt_len          = 20'd0;
    pkt_msgid        = 10'd0;
    pkt_is_eom       = 1'b0;
    pkt_ctx_id       = 3'd0;
    pkt_valid        = 1'b0;
    write_desc_ready = 1'b0;
    feedback_addr    = 32'd0;
    feedback_valid   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", pkt_ready, 0);
    chk("rst_valid", write_desc_valid, 0);
    chk("rst_free", free_count, 64);
    chk("rst_addr", write_desc_addr, 0);
    chk("rst_len", write_desc_len, 0);
    chk("rst_tag", write_desc_tag, 0);
    chk("rst_trunc", trunc_count, 0);
    chk("rst_ferr", free_err_count, 0);
    model_reset();
    rstn             = 1'b1;
    write_desc_ready = 1'b1;

    // First packet: one-cycle latency, tag encoding.
    pkt_len = 20'd100; pkt_msgid = 10'd5; pkt_is_eom = 1'b1; pkt_ctx_id = 3'd3;
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    chk("t1_addr", write_desc_addr, 32'h1C30_0000);
    chk("t1_len", write_desc_len, 100);
    chk("t1_tag", write_desc_tag, 32'h0000_005B);
    chk("t1_free", free_count, 63);
    tick();

    // Fill all 64 slots back to back.
    do_reset();
    pkt_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      pkt_len    = 20'($urandom_range(0, 2048));
      pkt_msgid  = 10'($urandom_range(0, 1023));
      pkt_is_eom = 1'($urandom_range(0, 1));
      pkt_ctx_id = 3'($urandom_range(0, 7));
      tick();
      chk("b2b_addr", write_desc_addr, BASE + 32'(n) * 32'h800);
    end
    pkt_valid = 1'b0;
    #1;
    chk("full_ready", pkt_ready, 0);
    chk("full_count", free_count, 0);

    // Free slot 2 from full; it is the next one handed out.
    feedback_addr = 32'h1C30_1000; feedback_valid = 1'b1;
    tick();
    feedback_valid = 1'b0;
    chk("t3_ready", pkt_ready, 1);
    pkt_len = 20'd64; pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    chk("t3_addr", write_desc_addr, 32'h1C30_1000);

    // Free slot 5, then free slot 0 in the same cycle as an accept: slot 5 wins.
    feedback_addr = 32'h1C30_2800; feedback_valid = 1'b1;
    tick();
    feedback_addr = 32'h1C30_0000; pkt_len = 20'd200; pkt_valid = 1'b1;
    tick();
    feedback_valid = 1'b0; pkt_valid = 1'b0;
    chk("t4_addr", write_desc_addr, 32'h1C30_2800);
    chk("t4_free", free_count, 1);

    // Truncation, then rejected frees.
    pkt_len = 20'd3000; pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    chk("t5_len", write_desc_len, 2048);
    chk("t5_trunc", trunc_count, 1);
    chk("t5_addr", write_desc_addr, 32'h1C30_0000);
    feedback_valid = 1'b1;
    feedback_addr = 32'h1C30_0004; tick();
    feedback_addr = 32'h1C34_0000; tick();
    feedback_addr = 32'h1C30_1000; tick();
    feedback_addr = 32'h1C30_1000; tick();
    chk("t5_ferr", free_err_count, 3);
    chk("t5_free", free_count, 1);
    feedback_addr = 32'h1C30_2800; tick();
    feedback_valid = 1'b0;
    chk("t6_free_pre", free_count, 2);

    // Backpressure: descriptor held stable, only one slot consumed.
    write_desc_ready = 1'b0;
    pkt_len = 20'd50; pkt_valid = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_valid", write_desc_valid, 1);
      chk("hold_addr", write_desc_addr, 32'h1C30_1000);
      chk("hold_len", write_desc_len, 50);
      chk("hold_free", free_count, 1);
    end

    // Reset while holding: descriptor dropped, all slots free.
    rstn = 1'b0; pkt_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_mid_valid", write_desc_valid, 0);
    chk("rst_mid_free", free_count, 64);
    model_reset();
    rstn = 1'b1;
    tick();
    chk("sb_drain", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
